// File: rtl/ws_array_ctrl.sv
// ---------------------------------------------------------------------------
// ws_array_ctrl
// Sequencing controller for a ROWS x COLS weight-stationary systolic array.
// A job runs three phases: LOAD shifts one weight row per cycle into the
// array (bottom row first), STREAM issues activation vectors as the buffer
// presents them (a low x_valid is a bubble), and DRAIN waits until the last
// issued vector has left the bottom row of every column.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   start         job request, sampled only in IDLE
//   cfg_n_vec     activation vector count, latched with start
//   busy, done    job status (done is a one-cycle pulse at job end)
//   w_load        weight-shift strobe to the row-0 PEs
//   w_addr        weight-buffer row address during LOAD
//   x_valid       activation buffer has a vector ready
//   x_rd          issue/pop strobe to the activation buffer
//   x_idx         index of the vector issued this cycle
//   en_row        en_in to the column-0 PE of each row (skewed)
//   clr_row       clr_in to the column-0 PE of each row
//   y_valid       bottom-row mac_out valid, per column
// ---------------------------------------------------------------------------
module ws_array_ctrl #(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned PE_LAT = 4,
    parameter int unsigned LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_n_vec,
    output logic                    busy,
    output logic                    done,
    output logic                    w_load,
    output logic [$clog2(ROWS)-1:0] w_addr,
    input  logic                    x_valid,
    output logic                    x_rd,
    output logic [LEN_W-1:0]        x_idx,
    output logic [ROWS-1:0]         en_row,
    output logic [ROWS-1:0]         clr_row,
    output logic [COLS-1:0]         y_valid
);

    localparam int unsigned AW        = $clog2(ROWS);
    // Cycles from an issue at the top-left PE to its result at the bottom of column 0.
    localparam int unsigned ARRAY_LAT = ROWS * PE_LAT;
    // Extra cycles after the final issue until y_valid[COLS-1] fires.
    localparam int unsigned DRAIN_LEN = ARRAY_LAT + COLS - 1;
    // Deepest tap of the issue delay line is y_valid[COLS-1].
    localparam int unsigned SKEW_LEN  = DRAIN_LEN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [LEN_W-1:0]    cnt;
    logic [LEN_W-1:0]    cnt_nxt;
    logic [LEN_W-1:0]    n_reg;
    logic [LEN_W-1:0]    n_nxt;
    logic                issue;
    logic [SKEW_LEN-1:0] skew;

    // State, shared phase counter and latched job length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            n_reg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            n_reg <= n_nxt;
        end
    end

    // Next-state logic; cnt is the LOAD row, the STREAM vector index or the DRAIN tick.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        n_nxt     = n_reg;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    state_nxt = S_LOAD;
                    n_nxt     = cfg_n_vec;
                end
            end
            S_LOAD: begin
                if (cnt == LEN_W'(ROWS - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = (n_reg == '0) ? S_DONE : S_STREAM;
                end else begin
                    cnt_nxt = cnt + LEN_W'(1);
                end
            end
            S_STREAM: begin
                issue = x_valid;
                if (x_valid) begin
                    // n_reg >= 1 here, so n_reg-1 cannot underflow; no early wrap at max length.
                    if (cnt == n_reg - LEN_W'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = S_DRAIN;
                    end else begin
                        cnt_nxt = cnt + LEN_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (cnt == LEN_W'(DRAIN_LEN - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + LEN_W'(1);
                end
            end
            S_DONE: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Status and load outputs registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            w_load <= 1'b0;
            w_addr <= '0;
            x_idx  <= '0;
        end else begin
            busy   <= (state_nxt != S_IDLE);
            done   <= (state_nxt == S_DONE);
            w_load <= (state_nxt == S_LOAD);
            // Bottom row's weight goes in first so it ends up ROWS-1 shifts deep.
            w_addr <= (state_nxt == S_LOAD) ? (AW'(ROWS - 1) - AW'(cnt_nxt)) : '0;
            x_idx  <= (state_nxt == S_STREAM) ? cnt_nxt : '0;
        end
    end

    // Issue delay line; free-running in every state, tap d-1 is issue delayed d cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skew <= '0;
        end else begin
            skew <= {skew[SKEW_LEN-2:0], issue};
        end
    end

    assign x_rd       = issue;
    assign en_row[0]  = issue;
    // Only the top row starts a fresh sum; lower rows accumulate psum_in.
    assign clr_row    = {{(ROWS-1){1'b0}}, issue};

    for (genvar r = 1; r < ROWS; r++) begin : g_en_row
        assign en_row[r] = skew[r*PE_LAT-1];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_y_valid
        assign y_valid[c] = skew[ARRAY_LAT+c-1];
    end

endmodule
